// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped I/O responder for the MMU I/O window.
// LED, synchronised switches, cycle timer with match IRQ, 4-deep TX FIFO + 8N1 UART.
module io_port_bank #(
    parameter int CLK_DIV = 104,
    parameter int LED_W   = 8,
    parameter int SW_W    = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [7:0]       io_addr,
    input  logic             io_en,
    input  logic             io_we,
    input  logic [31:0]      io_data_write,
    output logic [31:0]      io_data_read,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  sw,
    output logic             uart_tx,
    output logic             irq_timer
);

    localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TLAST = TW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    logic [31:0]      cnt_q, cmp_q;
    logic             match_q, ovf_q;
    logic [7:0]       mem_q [4];
    logic [1:0]       wp_q, rp_q;
    logic [2:0]       fcnt_q, fcnt_d;
    state_t           state_q;
    logic [7:0]       shift_q;
    logic [2:0]       bit_q;
    logic [TW-1:0]    tmr_q;
    logic             tx_q;

    logic [5:0] off;
    logic       wr, full, empty, busy, tdone;
    logic       push_req, push, pop, ovf_set;
    logic       unused_addr;

    assign off         = io_addr[7:2];
    assign unused_addr = ^io_addr[1:0];
    assign wr          = io_en & io_we;
    assign full        = (fcnt_q == 3'd4);
    assign empty       = (fcnt_q == 3'd0);
    assign busy        = (state_q != IDLE);
    assign tdone       = (tmr_q == TLAST);

    // The shifter takes a byte when idle, or at the end of a stop bit for back-to-back frames.
    assign pop      = !empty && ((state_q == IDLE) || ((state_q == STOP) && tdone));
    assign push_req = wr && (off == 6'd5);
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    assign led       = led_q;
    assign irq_timer = match_q;
    assign uart_tx   = tx_q;

    // Combinational read mux; unmapped offsets and idle bus read as zero.
    always_comb begin
        io_data_read = 32'd0;
        if (io_en) begin
            case (off)
                6'd0:    io_data_read = 32'(led_q);
                6'd1:    io_data_read = 32'(sw_s2_q);
                6'd2:    io_data_read = cnt_q;
                6'd3:    io_data_read = cmp_q;
                6'd4:    io_data_read = {31'd0, match_q};
                6'd6:    io_data_read = {28'd0, ovf_q, busy, empty, full};
                default: io_data_read = 32'd0;
            endcase
        end
    end

    // LED register and two-flop switch synchroniser.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            led_q   <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
            if (wr && off == 6'd0) led_q <= io_data_write[LED_W-1:0];
        end
    end

    // Free-running counter, compare register and sticky match flag (set beats clear).
    always_ff @(posedge clk) begin
        if (!resetb) begin
            cnt_q   <= '0;
            cmp_q   <= '1;
            match_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            if (wr && off == 6'd3) cmp_q <= io_data_write;
            if (cnt_q == cmp_q)
                match_q <= 1'b1;
            else if (wr && off == 6'd4 && io_data_write[0])
                match_q <= 1'b0;
        end
    end

    // FIFO occupancy next-state.
    always_comb begin
        fcnt_d = fcnt_q;
        if (push && !pop) fcnt_d = fcnt_q + 3'd1;
        if (pop && !push) fcnt_d = fcnt_q - 3'd1;
    end

    // FIFO pointers, count and sticky overflow (new overflow beats clear).
    always_ff @(posedge clk) begin
        if (!resetb) begin
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            if (push) wp_q <= wp_q + 2'd1;
            if (pop)  rp_q <= rp_q + 2'd1;
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (wr && off == 6'd6 && io_data_write[3])
                ovf_q <= 1'b0;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= io_data_write[7:0];
    end

    // 8N1 transmitter with registered line output.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shift_q <= mem_q[rp_q];
                        tmr_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    tmr_q <= tmr_q + TW'(1);
                    if (tdone) begin
                        tmr_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    tmr_q <= tmr_q + TW'(1);
                    if (tdone) begin
                        tmr_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    tmr_q <= tmr_q + TW'(1);
                    if (tdone) begin
                        tmr_q <= '0;
                        if (!empty) begin
                            shift_q <= mem_q[rp_q];
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
Memory-mapped I/O responder that terminates the MMU's I/O port bus (data-side window 0x80000000-0x800000FF, 8-bit offset).
Contents:
- LED output register
- synchronised switch input
- free-running cycle counter with compare/match flag and interrupt
- 4-entry TX FIFO feeding an 8N1 UART transmitter

Sits beside the MMU in the rv32i pipeline top level. Its pins go to board LEDs, switches and the UART TX pin.

Parameters:
- CLK_DIV, 104, clock cycles per UART bit (must be >=2)
- LED_W, 8, width of LED register/output (1..32)
- SW_W, 8, width of switch input (1..32)

Ports:
- clk  input  1  system clock
- resetb  input  1  synchronous active-low reset
- io_addr  input  8  byte offset within I/O window; [1:0] ignored
- io_en  input  1  access valid this cycle
- io_we  input  1  write when high, read when low (qualified by io_en)
- io_data_write  input  32  write data, already lane-shifted by MMU
- io_data_read  output  32  read data, combinational
- led  output  LED_W  LED register value
- sw  input  SW_W  asynchronous switch inputs
- uart_tx  output  1  serial output, idle high
- irq_timer  output  1  level interrupt, equals match flag

Behaviour:
Reset and bus rules:
- Reset (resetb low at posedge clk) values: led=0, uart_tx=1, irq_timer=0, counter=0, compare=0xFFFFFFFF, match flag=0, FIFO empty, overflow=0, UART idle, switch sync flops=0. Reset mid-frame abandons the frame; uart_tx is 1 the cycle after reset.
- Bus timing: the MMU presents io_addr/io_en/io_we/io_data_write registered, and samples io_data_read in the same cycle. io_data_read is a pure function of io_addr, io_en and current state. It is 0 when io_en=0 or the offset is unmapped.
- Writes commit at the posedge ending the cycle with io_en&io_we.
- No byte enables exist on this bus. A write updates the whole register from io_data_write. Software must use sw or lane-0 sb/sh.
- Unmapped writes are ignored.

Register map (offset, access):
- 0x00 LED, RW: bits [LED_W-1:0]; upper bits read 0.
- 0x04 SW, RO: 2-flop synchronised sw, zero-extended. Latency 2 cycles from pin.
- 0x08 COUNT, RO: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0. A read returns the pre-increment value of that cycle.
- 0x0C COMPARE, RW.
- 0x10 TSTAT: bit0 match flag. Set at posedge when counter==compare. Write 1 to bit0 clears it. Simultaneous set and clear -> set wins. irq_timer = flag.
- 0x14 TXDATA, WO (reads 0):
  - A write pushes io_data_write[7:0].
  - FIFO full -> push dropped, overflow set.
- 0x18 USTAT: bit0 full, bit1 empty, bit2 busy (shifter active), bit3 overflow (sticky, write 1 to clear; new overflow same cycle wins).

FIFO:
- Depth 4, 2-bit read/write pointers plus count (0..4).
- Push and pop in the same cycle when full: the pop happens and the push is accepted (count unchanged).
- Push into empty FIFO while UART idle: the byte is visible to the UART on the next cycle.

UART FSM (IDLE, START, DATA, STOP), bit timer counts CLK_DIV cycles:
- IDLE: uart_tx=1. If FIFO non-empty, pop into shift reg -> START.
- START: uart_tx=0 for CLK_DIV cycles -> DATA, bit index 0.
- DATA: uart_tx=shift[0], LSB first, CLK_DIV cycles per bit. After bit 7 -> STOP.
- STOP: uart_tx=1 for CLK_DIV cycles -> IDLE. A pending byte starts its START the cycle after STOP ends, so frames are back-to-back with no extra idle.
- busy = state!=IDLE.
- Frame length is exactly 10*CLK_DIV cycles.

Test Plan:
- Reset, then read 0x00,0x10,0x18 -> 0x0, 0x0, 0x2 (empty). uart_tx=1, irq_timer=0. Read with io_en=0 at 0x18 -> 0.
- Write 0x000000A5 to 0x00 -> led=0xA5 next cycle, read back 0xA5. Write to 0x40 -> no state change, read 0x40 -> 0. Drive sw=0x3C -> read 0x04 is 0x3C from the 3rd cycle on.
- Write 0x0C=50 after reset -> irq_timer rises 1 cycle after the counter is 50. Write 1 to 0x10 -> irq clears. Write 1 in the exact cycle counter==compare -> flag stays 1.
- CLK_DIV=4, write 0x55 to 0x14 -> uart_tx pattern 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each 4 cycles, 40 cycles total. USTAT busy set throughout.
- Five back-to-back writes 0x01..0x05 to 0x14 while idle -> 5 frames emitted back-to-back, no overflow (first byte popped before 5th push). Six writes while busy with FIFO holding 4 -> byte dropped, USTAT=0x9|0x4. Write 0x8 -> overflow cleared.
- Assert resetb mid-DATA -> uart_tx=1 next cycle, FIFO empty, USTAT=0x2, counter restarts at 0.
